// File: rtl/bram_fifo_pkg.sv
// Purpose : shared types and sizing rules for the BRAM-backed FIFO controller.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package bram_fifo_pkg;

  // Output-stage occupancy state: how many entries sit past the BRAM.
  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_ONE   = 2'd1,
    OUT_TWO   = 2'd2
  } out_state_e;

  // Counters must hold DEPTH+2 (BRAM entries plus the two output slots).
  function automatic int count_width(input int address_width);
    return address_width + 2;
  endfunction

  // Number of entries held by the output stage in a given state.
  function automatic logic [1:0] occ_of(input out_state_e s);
    logic [1:0] occ;
    case (s)
      OUT_ONE: occ = 2'd1;
      OUT_TWO: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/memcore_bram_simple.sv
// Purpose : simple dual-port BRAM, port 0 write-only, port 1 read-only with registered q1.
// Latency : read data on q1_o one cycle after ce1_i; q1_o holds while ce1_i=0.
// Backpr. : none; caller guarantees no same-address write/read in one cycle.
// Ports   : clk; ce0_i/we0_i/addr0_i/d0_i write port; ce1_i/addr1_i/q1_o read port.
module memcore_bram_simple #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     ce0_i,
  input  logic                     we0_i,
  input  logic [ADDRESS_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0]    d0_i,
  input  logic                     ce1_i,
  input  logic [ADDRESS_WIDTH-1:0] addr1_i,
  output logic [DATA_WIDTH-1:0]    q1_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] q1_q;

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ce0_i && we0_i) begin
      mem_q[addr0_i] <= d0_i;
    end
    if (ce1_i) begin
      q1_q <= mem_q[addr1_i];
    end
  end

  assign q1_o = q1_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Purpose : FWFT FIFO of DEPTH+2 entries: BRAM storage plus a two-slot output stage (q1 + skid).
// Latency : push into empty FIFO -> if_empty_n high two cycles later; 1 push + 1 pop per cycle sustained.
// Backpr. : if_full_n drops when the BRAM holds DEPTH entries; pushes while full and pops while empty are dropped.
// Ports   : clk, reset (sync, active-high); push side if_din/if_write/if_write_ce/if_full_n;
//           pop side if_dout/if_read/if_read_ce/if_empty_n; optional if_occupancy when
//           BRAM_FIFO_CTRL_OCCUPANCY_EN is defined. DEPTH must equal 2**ADDRESS_WIDTH.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DEPTH         = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   if_din,
  input  logic                    if_write,
  input  logic                    if_write_ce,
  output logic                    if_full_n,
  output logic [DATA_WIDTH-1:0]   if_dout,
  input  logic                    if_read,
  input  logic                    if_read_ce,
  output logic                    if_empty_n
`ifdef BRAM_FIFO_CTRL_OCCUPANCY_EN
  ,
  output logic [ADDRESS_WIDTH+1:0] if_occupancy
`endif
);

  localparam int COUNT_WIDTH = count_width(ADDRESS_WIDTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0]   mem_count_q, mem_count_d;
  out_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]    skid_q, skid_d;
  logic [DATA_WIDTH-1:0]    q1;
  logic                     mem_full;
  logic                     push;
  logic                     pop;
  logic                     rd_en;
  logic [1:0]               out_occ;
  logic [1:0]               occ_after_pop;

  assign mem_full = (mem_count_q >= COUNT_WIDTH'(DEPTH));
  assign push     = !reset && if_write && if_write_ce && !mem_full;
  assign pop      = !reset && if_read && if_read_ce && (state_q != OUT_EMPTY);

  // A read issued this cycle lands in q1 at the coming edge, so the only
  // entry "in flight" is this cycle's read; allow it only if the output
  // stage will still have a free slot after this cycle's pop.
  assign occ_after_pop = out_occ - {1'b0, pop};
  assign rd_en = !reset && (mem_count_q != '0) && (occ_after_pop < 2'd2);

  // While full, wr_ptr == rd_ptr but writes are blocked, so the BRAM never
  // sees the same address written and read in one cycle.
  assign wr_ptr_d    = wr_ptr_q + {{(ADDRESS_WIDTH-1){1'b0}}, push};
  assign rd_ptr_d    = rd_ptr_q + {{(ADDRESS_WIDTH-1){1'b0}}, rd_en};
  assign mem_count_d = mem_count_q + {{(COUNT_WIDTH-1){1'b0}}, push}
                                   - {{(COUNT_WIDTH-1){1'b0}}, rd_en};

  // q1 is about to be overwritten on every arrival; keep its old value in
  // skid. Only OUT_TWO ever reads skid, and the arrival-without-pop from
  // OUT_ONE plus the arrival-with-pop in OUT_TWO both need exactly this copy.
  assign skid_d = rd_en ? q1 : skid_q;

  memcore_bram_simple #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH        (DEPTH)
  ) u_mem (
    .clk    (clk),
    .ce0_i  (push),
    .we0_i  (push),
    .addr0_i(wr_ptr_q),
    .d0_i   (if_din),
    .ce1_i  (rd_en),
    .addr1_i(rd_ptr_q),
    .q1_o   (q1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state (arrival == rd_en this cycle)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (rd_en) state_d = OUT_ONE;
      OUT_ONE: begin
        if (rd_en && !pop)      state_d = OUT_TWO;
        else if (!rd_en && pop) state_d = OUT_EMPTY;
      end
      OUT_TWO:   if (!rd_en && pop) state_d = OUT_ONE;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // FSM: outputs. Reset forces the flags immediately so stale state never leaks out.
  always_comb begin
    out_occ    = occ_of(state_q);
    if_empty_n = !reset && (state_q != OUT_EMPTY);
    if_full_n  = reset || !mem_full;
    if_dout    = (state_q == OUT_TWO) ? skid_q : q1;
  end

`ifdef BRAM_FIFO_CTRL_OCCUPANCY_EN
  logic [ADDRESS_WIDTH+1:0] occupancy_q, occupancy_d;

  // BRAM entries plus output-stage entries after this edge.
  assign occupancy_d = mem_count_d + {{ADDRESS_WIDTH{1'b0}}, occ_of(state_d)};

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign if_occupancy = occupancy_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Purpose : directed self-checking bench for bram_fifo_ctrl with a push-order scoreboard.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpr. : pushes enter the scoreboard only when accepted; pops are checked against its head.
module tb_bram_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] if_din;
  logic          if_write;
  logic          if_write_ce;
  logic          if_full_n;
  logic [DW-1:0] if_dout;
  logic          if_read;
  logic          if_read_ce;
  logic          if_empty_n;
`ifdef BRAM_FIFO_CTRL_OCCUPANCY_EN
  logic [AW+1:0] if_occupancy;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_din     (if_din),
    .if_write   (if_write),
    .if_write_ce(if_write_ce),
    .if_full_n  (if_full_n),
    .if_dout    (if_dout),
    .if_read    (if_read),
    .if_read_ce (if_read_ce),
    .if_empty_n (if_empty_n)
`ifdef BRAM_FIFO_CTRL_OCCUPANCY_EN
    ,
    .if_occupancy(if_occupancy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: check a pop against the scoreboard, record an
  // accepted push, drive the inputs, then advance one full cycle.
  task automatic step(input logic w, input logic [31:0] d, input logic r,
                      input logic wce = 1'b1, input logic rce = 1'b1);
    logic [31:0] e;
    if (r && rce && if_empty_n) begin
      if (sb.size() == 0) begin
        chk("pop_with_empty_scoreboard", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("pop_data", if_dout, e);
      end
    end
    if (w && wce && if_full_n) sb.push_back(d);
    if_write    = w;
    if_din      = d;
    if_write_ce = wce;
    if_read     = r;
    if_read_ce  = rce;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    if_din      = '0;
    if_write    = 1'b0;
    if_write_ce = 1'b0;
    if_read     = 1'b0;
    if_read_ce  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_full_n", if_full_n, 1);
    chk("reset_empty_n", if_empty_n, 0);
    reset = 1'b0;
    step(0, 0, 0);
    chk("post_reset_full_n", if_full_n, 1);
    chk("post_reset_empty_n", if_empty_n, 0);

    // Single push: head valid two cycles after the push edge.
    step(1, 32'hA5A5_A5A5, 0);
    chk("lat_cycle1_empty_n", if_empty_n, 0);
    step(0, 0, 0);
    chk("lat_cycle2_empty_n", if_empty_n, 1);
    chk("lat_cycle2_dout", if_dout, 32'hA5A5_A5A5);
    step(0, 0, 1);
    chk("single_pop_empty_n", if_empty_n, 0);

    // Fill to DEPTH+2 without popping.
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1, i, 0);
      if (i == DEPTH) chk("fill65_full_n", if_full_n, 1);
    end
    chk("fill66_full_n", if_full_n, 0);
    step(1, 32'hDEAD_BEEF, 0);
    chk("fill67_full_n", if_full_n, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("drain_head", if_dout, i);
      step(0, 0, 1);
    end
    chk("drain_empty_n", if_empty_n, 0);
    chk("drain_full_n", if_full_n, 1);

    // Streaming push+pop: no bubbles once the pipe is primed, wraps 3 times.
    for (int i = 0; i < 200; i++) begin
      if (i >= 2) chk("stream_vld", if_empty_n, 1);
      step(1, 1000 + i, 1);
    end
    for (int k = 0; k < 6 && sb.size() > 0; k++) step(0, 0, 1);
    chk("stream_leftover", sb.size(), 0);
    chk("stream_empty_n", if_empty_n, 0);

    // Disabled enables change nothing.
    step(1, 32'h10, 0);
    step(1, 32'h11, 0);
    step(1, 32'h12, 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    chk("read_ce0_dout", if_dout, 32'h10);
    chk("read_ce0_empty_n", if_empty_n, 1);
    repeat (2) step(1, 32'h99, 0, 0, 1);
    repeat (3) step(0, 0, 1);
    chk("write_ce0_empty_n", if_empty_n, 0);

    // Pop while empty is ignored.
    step(0, 0, 1);
    step(1, 32'h55, 0);
    step(0, 0, 0);
    chk("after_empty_pop_dout", if_dout, 32'h55);
    step(0, 0, 1);
    chk("after_empty_pop_empty_n", if_empty_n, 0);

    // Reset mid-operation discards everything.
    for (int i = 0; i < 10; i++) step(1, 200 + i, 0);
    reset = 1'b1;
    if_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_empty_n", if_empty_n, 0);
    chk("midreset_full_n", if_full_n, 1);
    reset = 1'b0;
    sb.delete();
    step(1, 32'h1, 0);
    step(0, 0, 0);
    chk("postreset_head", if_dout, 32'h1);
    chk("postreset_empty_n", if_empty_n, 1);
    step(0, 0, 1);
    chk("postreset_drain_empty_n", if_empty_n, 0);

`ifdef BRAM_FIFO_CTRL_OCCUPANCY_EN
    for (int i = 0; i < 5; i++) step(1, 300 + i, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("occupancy", if_occupancy, 3);
    repeat (3) step(0, 0, 1);
    chk("occupancy_zero", if_occupancy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
